rr_arbiter_4: RTL and testbench

- Round-robin arbiter that shares one 2→4 one-hot select resource between four requesters, such as keys driving a shared LED or display group.
- Accepts level requests and issues a registered one-hot grant built from the 2-bit owner index via a 2→4 decode.
- Enforces a maximum grant tenure and one dead cycle between owners, so two select lines are never active together.
- Sits between the key/requester logic and the decoded-select datapath in hackathon_top-style designs.

---
 rtl/rr_arbiter_4.sv | 124 ++++++++++++
 tb/tb_rr_arbiter_4.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter driving a one-hot select resource.
// Each tenure is bounded by MAX_HOLD, and there is one dead cycle between owners.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic       gnt_valid_o,
    output logic [1:0] gnt_idx_o,
    output logic       timeout_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam bit                LIMIT_EN   = (MAX_HOLD != 0);

    state_t            state_q, state_d;
    logic [3:0]        gnt_q, gnt_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [1:0]        gnt_idx_q, gnt_idx_d;
    logic              timeout_q, timeout_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // Requests rotated so that bit 0 is the current highest-priority requester.
    logic [3:0] rot_req;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = req_i[ptr_q + 2'(gi)];
        end
    endgenerate

    logic [1:0] win_off;
    logic [1:0] winner;
    logic       owner_req;
    logic       limit_hit;

    always_comb begin
        win_off = 2'd3;
        if (rot_req[0]) begin
            win_off = 2'd0;
        end else if (rot_req[1]) begin
            win_off = 2'd1;
        end else if (rot_req[2]) begin
            win_off = 2'd2;
        end
    end

    assign winner    = ptr_q + win_off;
    assign owner_req = req_i[gnt_idx_q];
    assign limit_hit = LIMIT_EN && (hold_cnt_q == HOLD_LIMIT);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d       = 4'b0001 << winner;
                    gnt_idx_d   = winner;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = HOLD_ONE;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req || limit_hit) begin
                    // Revoked owner drops to lowest priority for the next round.
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 2'd1;
                    timeout_d   = limit_hit && owner_req;
                    state_d     = IDLE;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= 2'd0;
            timeout_q   <= 1'b0;
            ptr_q       <= 2'd0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = gnt_valid_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: three instances (MAX_HOLD 15, 3, 0) share req/reset.
// Directed scenarios plus randomized traffic are checked against a behavioural model.
module tb_rr_arbiter_4;

    logic       clock;
    logic       reset;
    logic [3:0] req;

    logic [3:0] gnt_w   [3];
    logic       valid_w [3];
    logic [1:0] idx_w   [3];
    logic       tout_w  [3];

    int n_total = 0;
    int n_bad   = 0;

    rr_arbiter_4 #(.MAX_HOLD(15), .HOLD_W(4)) u_h15 (
        .clock_i(clock), .reset_i(reset), .req_i(req),
        .gnt_o(gnt_w[0]), .gnt_valid_o(valid_w[0]), .gnt_idx_o(idx_w[0]), .timeout_o(tout_w[0])
    );
    rr_arbiter_4 #(.MAX_HOLD(3), .HOLD_W(4)) u_h3 (
        .clock_i(clock), .reset_i(reset), .req_i(req),
        .gnt_o(gnt_w[1]), .gnt_valid_o(valid_w[1]), .gnt_idx_o(idx_w[1]), .timeout_o(tout_w[1])
    );
    rr_arbiter_4 #(.MAX_HOLD(0), .HOLD_W(4)) u_h0 (
        .clock_i(clock), .reset_i(reset), .req_i(req),
        .gnt_o(gnt_w[2]), .gnt_valid_o(valid_w[2]), .gnt_idx_o(idx_w[2]), .timeout_o(tout_w[2])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: owner = -1 while nobody holds the resource; ten counts tenure cycles.
    typedef struct packed {
        int owner;
        int last;
        int ptr;
        int ten;
        int tout;
    } mstate_t;

    localparam mstate_t M_RESET = '{owner: -1, last: 0, ptr: 0, ten: 0, tout: 0};

    mstate_t ms [3];

    function automatic int maxh_of(int i);
        return (i == 0) ? 15 : ((i == 1) ? 3 : 0);
    endfunction

    function automatic mstate_t model_next(mstate_t s, logic [3:0] r, int maxh);
        mstate_t n;
        int      c;
        bit      lim;
        n      = s;
        n.tout = 0;
        if (s.owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                c = (s.ptr + k) % 4;
                if (r[c] && n.owner < 0) begin
                    n.owner = c;
                    n.last  = c;
                    n.ten   = 1;
                end
            end
        end else begin
            lim = (maxh != 0) && (s.ten >= maxh);
            if (!r[s.owner] || lim) begin
                n.tout  = (r[s.owner] && lim) ? 1 : 0;
                n.ptr   = (s.owner + 1) % 4;
                n.owner = -1;
            end else begin
                n.ten = s.ten + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) ms[i] <= M_RESET;
        end else begin
            for (int i = 0; i < 3; i++) ms[i] <= model_next(ms[i], req, maxh_of(i));
        end
    end

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                n_total++;
                if (gnt_w[i] !== 4'b0000 || valid_w[i] !== 1'b0 || idx_w[i] !== 2'd0 || tout_w[i] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_idle inst=%0d cyc=%0d got gnt=%b v=%b idx=%0d to=%b want 0000/0/0/0",
                             i, c, gnt_w[i], valid_w[i], idx_w[i], tout_w[i]);
                end
            end
        end
    endtask

    task automatic test_priority();
        apply_reset();
        req = 4'b1010;
        @(negedge clock);
        n_total++;
        if (gnt_w[0] !== 4'b0010 || idx_w[0] !== 2'd1 || valid_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_first got gnt=%b idx=%0d v=%b want 0010/1/1", gnt_w[0], idx_w[0], valid_w[0]);
        end
        req = 4'b1000;
        @(negedge clock);
        n_total++;
        if (gnt_w[0] !== 4'b0000 || valid_w[0] !== 1'b0 || tout_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_dead got gnt=%b v=%b to=%b want 0000/0/0", gnt_w[0], valid_w[0], tout_w[0]);
        end
        @(negedge clock);
        n_total++;
        if (gnt_w[0] !== 4'b1000 || idx_w[0] !== 2'd3) begin
            n_bad++;
            $display("FAIL prio_next got gnt=%b idx=%0d want 1000/3", gnt_w[0], idx_w[0]);
        end
    endtask

    // All four requesting: owner advances every (limit+1) cycles, last cycle is dead with timeout.
    task automatic test_rotation();
        logic [3:0] exp_g;
        logic       exp_t;
        int         per;
        apply_reset();
        req = 4'b1111;
        for (int t = 0; t < 80; t++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                per   = maxh_of(i) + 1;
                exp_t = ((t % per) == per - 1);
                exp_g = exp_t ? 4'b0000 : (4'b0001 << ((t / per) % 4));
                n_total++;
                if (gnt_w[i] !== exp_g || tout_w[i] !== exp_t || $countones(gnt_w[i]) > 1) begin
                    n_bad++;
                    $display("FAIL rotation inst=%0d t=%0d got gnt=%b to=%b want gnt=%b to=%b",
                             i, t, gnt_w[i], tout_w[i], exp_g, exp_t);
                end
            end
        end
    endtask

    task automatic test_single_timeout();
        logic [3:0] exp_g;
        logic       exp_t;
        apply_reset();
        req = 4'b0100;
        for (int t = 0; t < 24; t++) begin
            @(negedge clock);
            exp_t = ((t % 4) == 3);
            exp_g = exp_t ? 4'b0000 : 4'b0100;
            n_total++;
            if (gnt_w[1] !== exp_g || tout_w[1] !== exp_t || idx_w[1] !== 2'd2) begin
                n_bad++;
                $display("FAIL single_to t=%0d got gnt=%b to=%b idx=%0d want gnt=%b to=%b idx=2",
                         t, gnt_w[1], tout_w[1], idx_w[1], exp_g, exp_t);
            end
        end
    endtask

    task automatic test_no_limit();
        apply_reset();
        req = 4'b0001;
        for (int t = 0; t < 100; t++) begin
            @(negedge clock);
            n_total++;
            if (gnt_w[2] !== 4'b0001 || tout_w[2] !== 1'b0 || valid_w[2] !== 1'b1) begin
                n_bad++;
                $display("FAIL no_limit t=%0d got gnt=%b to=%b v=%b want 0001/0/1",
                         t, gnt_w[2], tout_w[2], valid_w[2]);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b1000;
        @(negedge clock);
        @(negedge clock);
        n_total++;
        if (gnt_w[0] !== 4'b1000) begin
            n_bad++;
            $display("FAIL arst_pre got gnt=%b want 1000", gnt_w[0]);
        end
        #1 reset = 1'b1;
        #1;
        n_total++;
        if (gnt_w[0] !== 4'b0000 || valid_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_drop got gnt=%b v=%b want 0000/0", gnt_w[0], valid_w[0]);
        end
        req = 4'b1001;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_total++;
        if (gnt_w[0] !== 4'b0001 || idx_w[0] !== 2'd0) begin
            n_bad++;
            $display("FAIL arst_ptr got gnt=%b idx=%0d want 0001/0", gnt_w[0], idx_w[0]);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_g;
        apply_reset();
        for (int t = 0; t < 400; t++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                exp_g = (ms[i].owner < 0) ? 4'b0000 : (4'b0001 << ms[i].owner);
                n_total++;
                if (gnt_w[i] !== exp_g || valid_w[i] !== (ms[i].owner >= 0) ||
                    idx_w[i] !== 2'(ms[i].last) || tout_w[i] !== (ms[i].tout != 0)) begin
                    n_bad++;
                    $display("FAIL random inst=%0d t=%0d got gnt=%b v=%b idx=%0d to=%b want gnt=%b idx=%0d to=%0d",
                             i, t, gnt_w[i], valid_w[i], idx_w[i], tout_w[i], exp_g, ms[i].last, ms[i].tout);
                end
            end
            if ($urandom_range(0, 5) == 0) begin
                req = 4'($urandom_range(0, 15));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        test_reset();
        test_priority();
        test_rotation();
        test_single_timeout();
        test_no_limit();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
